// File: rtl/tron_pkg.sv
// Shared Tron game types: phase encoding, winner codes and frame-rate default.
package tron_pkg;

    localparam int unsigned DEFAULT_FPS = 60;

    typedef enum logic [2:0] {
        GS_TITLE      = 3'd0,
        GS_COUNTDOWN  = 3'd1,
        GS_PLAY       = 3'd2,
        GS_ROUND_OVER = 3'd3,
        GS_GAME_OVER  = 3'd4
    } game_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_BLUE = 2'b01,
        WIN_RED  = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    // Winner code from the raw win pulses; both set means a draw.
    function automatic winner_t winner_code(input logic red_w, input logic blue_w);
        return winner_t'({red_w, blue_w});
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Sequencer bus: key/score inputs towards game_ctrl, phase outputs back out.
interface game_ctrl_if;
    import tron_pkg::*;

    logic        start_key;
    logic        reset_round;
    logic        Blue_W;
    logic        Red_W;
    game_state_t Game_State;
    logic        clear_arena;
    logic        bikes_enable;
    logic [1:0]  countdown;
    winner_t     winner;

    // The sequencer itself.
    modport master (
        input  start_key, reset_round, Blue_W, Red_W,
        output Game_State, clear_arena, bikes_enable, countdown, winner
    );

    // Keyboard decoder / score side.
    modport slave (
        output start_key, reset_round, Blue_W, Red_W,
        input  Game_State, clear_arena, bikes_enable, countdown, winner
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Brings an asynchronous strobe into the clock domain and emits one pulse per rising edge.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic tick
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic tick_q,  tick_d;

    // Two-flop synchronizer followed by a registered rising-edge detect.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        tick_d  = sync2_q & ~prev_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_ctrl.sv
// Tron game sequencer: title, countdown, play, round-over and game-over phases timed in frames.
module game_ctrl
    import tron_pkg::*;
#(
    parameter int unsigned FPS             = DEFAULT_FPS,
    parameter int unsigned COUNTDOWN_SECS  = 3,
    parameter int unsigned ROUND_OVER_SECS = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    game_ctrl_if.master bus
);

    localparam int unsigned MAX_SECS = (COUNTDOWN_SECS > ROUND_OVER_SECS) ? COUNTDOWN_SECS
                                                                           : ROUND_OVER_SECS;
    localparam int unsigned SEC_W    = $clog2(MAX_SECS + 1);
    localparam int unsigned FRAME_W  = (FPS > 1) ? $clog2(FPS) : 1;

    logic                frame_tick;
    logic                start_edge;
    logic                frame_last;
    logic                sec_wrap;
    logic                sec_expire;
    logic                any_win;

    game_state_t         state_q,     state_d;
    logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [SEC_W-1:0]    sec_cnt_q,   sec_cnt_d;
    winner_t             winner_q,    winner_d;
    logic                start_prev_q, start_prev_d;
    logic                clear_q,     clear_d;
    logic                bikes_q,     bikes_d;
    logic [1:0]          countdown_q, countdown_d;

    frame_tick_gen u_frame_tick (
        .clk      (Clk),
        .rst      (Reset),
        .async_in (frame_clk),
        .tick     (frame_tick)
    );

    // Start key is already synchronous; only its rising edge matters.
    assign start_edge = bus.start_key & ~start_prev_q;
    assign frame_last = (frame_cnt_q == FRAME_W'(FPS - 1));
    assign sec_wrap   = frame_tick & frame_last;
    assign sec_expire = sec_wrap & (sec_cnt_q == SEC_W'(1));
    assign any_win    = bus.Blue_W | bus.Red_W;

    // Next-state, counter datapath and registered-output values.
    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        sec_cnt_d    = sec_cnt_q;
        winner_d     = winner_q;
        start_prev_d = bus.start_key;
        clear_d      = 1'b0;

        case (state_q)
            GS_TITLE: begin
                if (start_edge) begin
                    state_d     = GS_COUNTDOWN;
                    sec_cnt_d   = SEC_W'(COUNTDOWN_SECS);
                    frame_cnt_d = '0;
                    winner_d    = WIN_NONE;
                    clear_d     = 1'b1;
                end
            end

            GS_COUNTDOWN: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_last ? '0 : frame_cnt_q + FRAME_W'(1);
                    if (sec_wrap) begin
                        sec_cnt_d = sec_cnt_q - SEC_W'(1);
                    end
                    if (sec_expire) begin
                        state_d = GS_PLAY;
                    end
                end
            end

            GS_PLAY: begin
                if (any_win) begin
                    state_d  = GS_GAME_OVER;
                    winner_d = winner_code(bus.Red_W, bus.Blue_W);
                end else if (bus.reset_round) begin
                    state_d     = GS_ROUND_OVER;
                    sec_cnt_d   = SEC_W'(ROUND_OVER_SECS);
                    frame_cnt_d = '0;
                end
            end

            GS_ROUND_OVER: begin
                // A late win from score beats the pause expiring.
                if (any_win) begin
                    state_d  = GS_GAME_OVER;
                    winner_d = winner_code(bus.Red_W, bus.Blue_W);
                end else if (frame_tick) begin
                    frame_cnt_d = frame_last ? '0 : frame_cnt_q + FRAME_W'(1);
                    if (sec_wrap) begin
                        sec_cnt_d = sec_cnt_q - SEC_W'(1);
                    end
                    if (sec_expire) begin
                        state_d     = GS_COUNTDOWN;
                        sec_cnt_d   = SEC_W'(COUNTDOWN_SECS);
                        frame_cnt_d = '0;
                        clear_d     = 1'b1;
                    end
                end
            end

            GS_GAME_OVER: begin
                if (start_edge) begin
                    state_d = GS_TITLE;
                end
            end

            default: begin
                state_d = GS_TITLE;
            end
        endcase

        bikes_d     = (state_d == GS_PLAY);
        countdown_d = (state_d == GS_COUNTDOWN) ? 2'(sec_cnt_d) : 2'd0;
    end

    // State, counters and outputs; reset aborts any phase.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= GS_TITLE;
            frame_cnt_q  <= '0;
            sec_cnt_q    <= '0;
            winner_q     <= WIN_NONE;
            start_prev_q <= 1'b1;
            clear_q      <= 1'b0;
            bikes_q      <= 1'b0;
            countdown_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            sec_cnt_q    <= sec_cnt_d;
            winner_q     <= winner_d;
            start_prev_q <= start_prev_d;
            clear_q      <= clear_d;
            bikes_q      <= bikes_d;
            countdown_q  <= countdown_d;
        end
    end

    assign bus.Game_State   = state_q;
    assign bus.clear_arena  = clear_q;
    assign bus.bikes_enable = bikes_q;
    assign bus.countdown    = countdown_q;
    assign bus.winner       = winner_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with FPS=4 (countdown 12 ticks, round-over 8 ticks).
module tb_game_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_clk = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    game_ctrl_if gif ();

    game_ctrl #(.FPS(4), .COUNTDOWN_SECS(3), .ROUND_OVER_SECS(2)) dut (
        .Clk       (clk),
        .Reset     (rst),
        .frame_clk (frame_clk),
        .bus       (gif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise frame_clk; the FSM consumes the resulting tick on the 4th edge.
    task automatic tick_edge(input logic bw);
        frame_clk = 1'b1;
        step(); step(); step();
        gif.Blue_W = bw;
        step();
        gif.Blue_W = 1'b0;
    endtask

    task automatic tick_low();
        frame_clk = 1'b0;
        repeat (4) step();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_edge(1'b0);
            tick_low();
        end
    endtask

    task automatic press_start();
        gif.start_key = 1'b1;
        step();
        gif.start_key = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        vectors++; if (gif.Game_State !== 3'd0) begin $display("FAIL reset_state got %0d want 0", gif.Game_State); miscompares++; end
        vectors++; if (gif.clear_arena !== 1'b0) begin $display("FAIL reset_clear got %0b want 0", gif.clear_arena); miscompares++; end
        vectors++; if (gif.bikes_enable !== 1'b0) begin $display("FAIL reset_bikes got %0b want 0", gif.bikes_enable); miscompares++; end
        vectors++; if (gif.countdown !== 2'd0) begin $display("FAIL reset_countdown got %0d want 0", gif.countdown); miscompares++; end
        vectors++; if (gif.winner !== 2'b00) begin $display("FAIL reset_winner got %0b want 00", gif.winner); miscompares++; end
    endtask

    task automatic test_start_countdown();
        gif.start_key = 1'b1;
        step();
        vectors++; if (gif.Game_State !== 3'd1) begin $display("FAIL start_state got %0d want 1", gif.Game_State); miscompares++; end
        vectors++; if (gif.clear_arena !== 1'b1) begin $display("FAIL start_clear got %0b want 1", gif.clear_arena); miscompares++; end
        vectors++; if (gif.countdown !== 2'd3) begin $display("FAIL start_countdown got %0d want 3", gif.countdown); miscompares++; end
        step();
        gif.start_key = 1'b0;
        vectors++; if (gif.clear_arena !== 1'b0) begin $display("FAIL start_clear_drop got %0b want 0", gif.clear_arena); miscompares++; end
        for (int k = 1; k <= 11; k++) begin
            tick_edge(1'b0);
            tick_low();
            if (k == 4) begin
                vectors++; if (gif.countdown !== 2'd2) begin $display("FAIL cd_after4 got %0d want 2", gif.countdown); miscompares++; end
            end
            if (k == 8) begin
                vectors++; if (gif.countdown !== 2'd1) begin $display("FAIL cd_after8 got %0d want 1", gif.countdown); miscompares++; end
            end
        end
        vectors++; if (gif.Game_State !== 3'd1) begin $display("FAIL cd_after11 got %0d want 1", gif.Game_State); miscompares++; end
        tick_edge(1'b0);
        vectors++; if (gif.Game_State !== 3'd2) begin $display("FAIL play_state got %0d want 2", gif.Game_State); miscompares++; end
        vectors++; if (gif.bikes_enable !== 1'b1) begin $display("FAIL play_bikes got %0b want 1", gif.bikes_enable); miscompares++; end
        vectors++; if (gif.countdown !== 2'd0) begin $display("FAIL play_countdown got %0d want 0", gif.countdown); miscompares++; end
        tick_low();
    endtask

    task automatic test_round_over();
        gif.reset_round = 1'b1;
        step();
        gif.reset_round = 1'b0;
        vectors++; if (gif.Game_State !== 3'd3) begin $display("FAIL ro_state got %0d want 3", gif.Game_State); miscompares++; end
        vectors++; if (gif.bikes_enable !== 1'b0) begin $display("FAIL ro_bikes got %0b want 0", gif.bikes_enable); miscompares++; end
        run_ticks(7);
        vectors++; if (gif.Game_State !== 3'd3) begin $display("FAIL ro_after7 got %0d want 3", gif.Game_State); miscompares++; end
        tick_edge(1'b0);
        vectors++; if (gif.Game_State !== 3'd1) begin $display("FAIL ro_expire got %0d want 1", gif.Game_State); miscompares++; end
        vectors++; if (gif.clear_arena !== 1'b1) begin $display("FAIL ro_clear got %0b want 1", gif.clear_arena); miscompares++; end
        vectors++; if (gif.countdown !== 2'd3) begin $display("FAIL ro_reload got %0d want 3", gif.countdown); miscompares++; end
        tick_low();
        vectors++; if (gif.clear_arena !== 1'b0) begin $display("FAIL ro_clear_drop got %0b want 0", gif.clear_arena); miscompares++; end
        run_ticks(11);
        vectors++; if (gif.Game_State !== 3'd1) begin $display("FAIL ro_cd11 got %0d want 1", gif.Game_State); miscompares++; end
        run_ticks(1);
        vectors++; if (gif.Game_State !== 3'd2) begin $display("FAIL ro_play got %0d want 2", gif.Game_State); miscompares++; end
    endtask

    task automatic test_win_after_round();
        gif.reset_round = 1'b1;
        step();
        gif.reset_round = 1'b0;
        gif.Blue_W = 1'b1;
        vectors++; if (gif.Game_State !== 3'd3) begin $display("FAIL war_ro got %0d want 3", gif.Game_State); miscompares++; end
        step();
        gif.Blue_W = 1'b0;
        vectors++; if (gif.Game_State !== 3'd4) begin $display("FAIL war_over got %0d want 4", gif.Game_State); miscompares++; end
        vectors++; if (gif.winner !== 2'b01) begin $display("FAIL war_winner got %0b want 01", gif.winner); miscompares++; end
        gif.Red_W = 1'b1;
        gif.reset_round = 1'b1;
        step();
        gif.Red_W = 1'b0;
        gif.reset_round = 1'b0;
        run_ticks(2);
        vectors++; if (gif.Game_State !== 3'd4) begin $display("FAIL war_hold_state got %0d want 4", gif.Game_State); miscompares++; end
        vectors++; if (gif.winner !== 2'b01) begin $display("FAIL war_hold_winner got %0b want 01", gif.winner); miscompares++; end
        press_start();
        vectors++; if (gif.Game_State !== 3'd0) begin $display("FAIL war_title got %0d want 0", gif.Game_State); miscompares++; end
        vectors++; if (gif.winner !== 2'b01) begin $display("FAIL war_title_winner got %0b want 01", gif.winner); miscompares++; end
        step();
        press_start();
        vectors++; if (gif.winner !== 2'b00) begin $display("FAIL war_restart_winner got %0b want 00", gif.winner); miscompares++; end
        run_ticks(12);
        vectors++; if (gif.Game_State !== 3'd2) begin $display("FAIL war_play got %0d want 2", gif.Game_State); miscompares++; end
    endtask

    task automatic test_draw();
        gif.Blue_W = 1'b1;
        gif.Red_W = 1'b1;
        step();
        gif.Blue_W = 1'b0;
        gif.Red_W = 1'b0;
        vectors++; if (gif.Game_State !== 3'd4) begin $display("FAIL draw_state got %0d want 4", gif.Game_State); miscompares++; end
        vectors++; if (gif.winner !== 2'b11) begin $display("FAIL draw_winner got %0b want 11", gif.winner); miscompares++; end
        step();
        press_start();
        vectors++; if (gif.Game_State !== 3'd0) begin $display("FAIL draw_title got %0d want 0", gif.Game_State); miscompares++; end
        repeat (5) step();
        vectors++; if (gif.winner !== 2'b11) begin $display("FAIL draw_title_winner got %0b want 11", gif.winner); miscompares++; end
        press_start();
        vectors++; if (gif.Game_State !== 3'd1) begin $display("FAIL draw_restart got %0d want 1", gif.Game_State); miscompares++; end
        vectors++; if (gif.winner !== 2'b00) begin $display("FAIL draw_restart_winner got %0b want 00", gif.winner); miscompares++; end
        run_ticks(12);
    endtask

    task automatic test_expire_win();
        gif.reset_round = 1'b1;
        step();
        gif.reset_round = 1'b0;
        run_ticks(7);
        tick_edge(1'b1);
        vectors++; if (gif.Game_State !== 3'd4) begin $display("FAIL expwin_state got %0d want 4", gif.Game_State); miscompares++; end
        vectors++; if (gif.winner !== 2'b01) begin $display("FAIL expwin_winner got %0b want 01", gif.winner); miscompares++; end
        vectors++; if (gif.clear_arena !== 1'b0) begin $display("FAIL expwin_clear got %0b want 0", gif.clear_arena); miscompares++; end
        tick_low();
    endtask

    task automatic test_held_start_reset();
        gif.start_key = 1'b1;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        repeat (4) step();
        vectors++; if (gif.Game_State !== 3'd0) begin $display("FAIL held_state got %0d want 0", gif.Game_State); miscompares++; end
        gif.start_key = 1'b0;
        step();
        vectors++; if (gif.Game_State !== 3'd0) begin $display("FAIL held_release got %0d want 0", gif.Game_State); miscompares++; end
        press_start();
        vectors++; if (gif.Game_State !== 3'd1) begin $display("FAIL held_repress got %0d want 1", gif.Game_State); miscompares++; end
    endtask

    task automatic test_reset_mid();
        run_ticks(2);
        gif.reset_round = 1'b1;
        gif.Blue_W = 1'b1;
        gif.Red_W = 1'b1;
        step();
        gif.reset_round = 1'b0;
        gif.Blue_W = 1'b0;
        gif.Red_W = 1'b0;
        vectors++; if (gif.Game_State !== 3'd1) begin $display("FAIL cd_ignore_state got %0d want 1", gif.Game_State); miscompares++; end
        vectors++; if (gif.winner !== 2'b00) begin $display("FAIL cd_ignore_winner got %0b want 00", gif.winner); miscompares++; end
        vectors++; if (gif.countdown !== 2'd3) begin $display("FAIL cd_ignore_cd got %0d want 3", gif.countdown); miscompares++; end
        rst = 1'b1;
        step();
        vectors++; if (gif.Game_State !== 3'd0) begin $display("FAIL rcd_state got %0d want 0", gif.Game_State); miscompares++; end
        vectors++; if (gif.countdown !== 2'd0) begin $display("FAIL rcd_countdown got %0d want 0", gif.countdown); miscompares++; end
        rst = 1'b0;
        step();
        press_start();
        run_ticks(12);
        vectors++; if (gif.Game_State !== 3'd2) begin $display("FAIL rro_play got %0d want 2", gif.Game_State); miscompares++; end
        gif.reset_round = 1'b1;
        step();
        gif.reset_round = 1'b0;
        run_ticks(3);
        vectors++; if (gif.Game_State !== 3'd3) begin $display("FAIL rro_pre got %0d want 3", gif.Game_State); miscompares++; end
        rst = 1'b1;
        step();
        vectors++; if (gif.Game_State !== 3'd0) begin $display("FAIL rro_state got %0d want 0", gif.Game_State); miscompares++; end
        vectors++; if (gif.clear_arena !== 1'b0) begin $display("FAIL rro_clear got %0b want 0", gif.clear_arena); miscompares++; end
        vectors++; if (gif.bikes_enable !== 1'b0) begin $display("FAIL rro_bikes got %0b want 0", gif.bikes_enable); miscompares++; end
        vectors++; if (gif.winner !== 2'b00) begin $display("FAIL rro_winner got %0b want 00", gif.winner); miscompares++; end
        rst = 1'b0;
        run_ticks(9);
        vectors++; if (gif.Game_State !== 3'd0) begin $display("FAIL rro_stay got %0d want 0", gif.Game_State); miscompares++; end
    endtask

    initial begin
        gif.start_key   = 1'b0;
        gif.reset_round = 1'b0;
        gif.Blue_W      = 1'b0;
        gif.Red_W       = 1'b0;
        test_reset();
        test_start_countdown();
        test_round_over();
        test_win_after_round();
        test_draw();
        test_expire_win();
        test_held_start_reset();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level Tron game sequencer, directly downstream of the `score` block. It consumes `reset_round` and the win flags (`Blue_W`, `Red_W`) and produces the 3-bit `Game_State` that `score`, the bike movers and the renderer all key off. It runs title, countdown, play, round-over and game-over phases. The phase timers count frames, not clock cycles.

## Interface
- `FPS`, default 60: frame ticks per second.
- `COUNTDOWN_SECS`, default 3: countdown length in seconds. Legal range 1..3.
- `ROUND_OVER_SECS`, default 2: pause length after a crash, in seconds.
- `Clk` input 1: 50 MHz system clock.
- `Reset` input 1: synchronous, active-high reset.
- `frame_clk` input 1: ~60 Hz frame strobe, asynchronous to the game logic.
- `start_key` input 1: level signal from the keyboard decoder, 1 while Enter is held.
- `reset_round` input 1: one-cycle pulse from `score` when a bike crashes.
- `Blue_W`, `Red_W` input 1 each: one-cycle win pulses from `score`.
- `Game_State` output 3: current phase, encoding below.
- `clear_arena` output 1: one-cycle pulse that respawns the bikes and wipes the trails.
- `bikes_enable` output 1: 1 only in PLAY.
- `countdown` output 2: seconds remaining, shown during COUNTDOWN; 0 otherwise.
- `winner` output 2: 00 none, 01 blue, 10 red, 11 draw. Holds its value through GAME_OVER.

## Operation
- State encoding: TITLE=0, COUNTDOWN=1, PLAY=2, ROUND_OVER=3, GAME_OVER=4. `score` clears its scores whenever `Game_State` is 0.
- `frame_tick`: `frame_clk` passes through a 2-flop synchronizer, then a rising-edge detector. Result is a one-cycle pulse per frame.
- `start_edge`: rising edge of `start_key`. The previous-value flop resets to 1, so a key held through reset does not fire.
- Counters: `frame_cnt` counts 0..FPS-1 and advances on `frame_tick`. `sec_cnt` holds whole seconds remaining and decrements when `frame_cnt` wraps.
- TITLE:
  - `start_edge` → COUNTDOWN.
  - `sec_cnt` loads COUNTDOWN_SECS, `frame_cnt` loads 0, `winner` loads 00, `clear_arena` pulses.
- COUNTDOWN:
  - On the wrap tick with `sec_cnt`==1 → PLAY.
  - `Blue_W`, `Red_W`, `reset_round` are ignored.
- PLAY:
  - `Blue_W` or `Red_W` → GAME_OVER, and `winner` latches {`Red_W`,`Blue_W`}.
  - Otherwise `reset_round` → ROUND_OVER, with `sec_cnt` loading ROUND_OVER_SECS and `frame_cnt` loading 0.
  - Win has priority over `reset_round` in the same cycle.
- ROUND_OVER:
  - `score` raises `reset_round` one cycle before the winning `X_W`, so win pulses are still honoured here: `X_W` → GAME_OVER with `winner` latched.
  - On the wrap tick with `sec_cnt`==1 → COUNTDOWN. This reloads the countdown and pulses `clear_arena`.
- GAME_OVER:
  - `winner` is held.
  - `start_edge` → TITLE.
  - Further `X_W` and `reset_round` pulses are ignored.
- `Reset` has priority over every transition. It forces TITLE with all counters 0 and `winner`=00, and aborts any phase immediately.

## Timing
- Reset values: `Game_State`=0, `clear_arena`=0, `bikes_enable`=0, `countdown`=0, `winner`=00.
- All outputs are registered. Each takes effect on the clock edge where the state register is updated.
- `clear_arena` is high for exactly the first cycle in COUNTDOWN.
- `countdown` equals `sec_cnt` throughout COUNTDOWN, e.g. 3,2,1 for the defaults.
- `frame_clk` to `frame_tick` latency: 3 `Clk` cycles.
- COUNTDOWN lasts exactly COUNTDOWN_SECS×FPS frame ticks; ROUND_OVER lasts exactly ROUND_OVER_SECS×FPS ticks.
- An `X_W` pulse in the same cycle as the ROUND_OVER expiry wins: next state is GAME_OVER.
- A `frame_tick` arriving in the cycle the counters load is not counted.

## Structure
- `tron_pkg` holds:
  - the `game_state_t` enum (3-bit, values above), shared with `score` and the renderer;
  - the `winner_t` codes;
  - the default FPS constant.
- One sub-module, `frame_tick_gen`: synchronizer plus edge detector. It is instanced once for `frame_clk`. The start key uses the same edge logic inline.
- The remaining logic is one registered FSM with counter datapath.

## Test plan
Bench uses FPS=4.
- Reset, then a `start_key` rising edge:
  - next cycle `Game_State`=1, `clear_arena`=1 for one cycle, `countdown`=3;
  - after 12 frame ticks, `Game_State`=2 and `bikes_enable`=1.
- In PLAY, `reset_round` pulse:
  - `Game_State`=3 for 8 ticks;
  - then `Game_State`=1 with a `clear_arena` pulse, then PLAY after 12 ticks.
- In PLAY, `reset_round` followed one cycle later by `Blue_W`: `Game_State`=3 then 4, `winner`=01 and holds.
- `Blue_W` and `Red_W` pulsed together in PLAY → `winner`=11, `Game_State`=4. A `start_key` edge then gives `Game_State`=0 and `winner` stays 11 until the next start.
- `start_key` held across the deassertion of `Reset` → `Game_State` stays 0 until the key is released and pressed again.
- `Reset` asserted mid-COUNTDOWN and mid-ROUND_OVER → next cycle all outputs return to their reset values; `reset_round` and `X_W` pulses in COUNTDOWN are ignored.
